ariele_slave_arbiter: RTL and testbench

//  Round-robin arbiter sharing one crossbar slave port (tile HPI or gpio) among NUM_M masters (tiles + udm).

---
 rtl/ariele_slave_arbiter_if.sv | 39 +++
 rtl/ariele_slave_arbiter.sv | 176 +++++++++++++++++
 tb/tb_ariele_slave_arbiter.sv | 339 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ariele_slave_arbiter_if.sv
// Bus bundle between NUM_M requesting masters, the slave arbiter and the shared slave port.
// The slave modport is the arbiter's view; the master modport is the surrounding fabric's view.
interface ariele_slave_arbiter_if #(
   parameter int NUM_M = 5
);
   logic [NUM_M-1:0]    m_req_i;
   logic [NUM_M-1:0]    m_we_i;
   logic [NUM_M*32-1:0] m_addr_bi;
   logic [NUM_M*4-1:0]  m_be_i;
   logic [NUM_M*32-1:0] m_wdata_bi;
   logic [NUM_M-1:0]    m_ack_o;
   logic [NUM_M-1:0]    m_resp_o;
   logic [31:0]         m_rdata_bo;
   logic                s_req_o;
   logic                s_we_o;
   logic [31:0]         s_addr_bo;
   logic [3:0]          s_be_o;
   logic [31:0]         s_wdata_bo;
   logic                s_ack_i;
   logic                s_resp_i;
   logic [31:0]         s_rdata_bi;
   logic                unexp_resp_o;

   modport slave (
      input  m_req_i, m_we_i, m_addr_bi, m_be_i, m_wdata_bi,
      input  s_ack_i, s_resp_i, s_rdata_bi,
      output m_ack_o, m_resp_o, m_rdata_bo,
      output s_req_o, s_we_o, s_addr_bo, s_be_o, s_wdata_bo,
      output unexp_resp_o
   );

   modport master (
      output m_req_i, m_we_i, m_addr_bi, m_be_i, m_wdata_bi,
      output s_ack_i, s_resp_i, s_rdata_bi,
      input  m_ack_o, m_resp_o, m_rdata_bo,
      input  s_req_o, s_we_o, s_addr_bo, s_be_o, s_wdata_bo,
      input  unexp_resp_o
   );
endinterface

// File: rtl/ariele_slave_arbiter.sv
// Round-robin arbiter sharing one crossbar slave port among NUM_M masters, with an ID FIFO that
// routes read responses back to their issuers. Define ARIELE_ARB_STATS_EN for grant/stall counters.
module ariele_slave_arbiter #(
   parameter int NUM_M = 5,
   parameter int OUTST = 4,
   parameter int PTR_W = 3
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   ariele_slave_arbiter_if.slave bus
`ifdef ARIELE_ARB_STATS_EN
   ,
   output logic [NUM_M*16-1:0]  stat_grant_bo,
   output logic [15:0]          stat_stall_bo
`endif
);

   localparam int                AW       = $clog2(OUTST);
   localparam logic [AW:0]       CNT_FULL = (AW+1)'(OUTST);
   localparam logic [PTR_W-1:0]  LAST_M   = PTR_W'(NUM_M - 1);

   logic [PTR_W-1:0] rr_ptr_q;
   logic [PTR_W-1:0] rr_ptr_d;
   logic [PTR_W-1:0] gnt;
   logic             any_req;
   logic             blocked;
   logic             fwd;
   logic             accept;
   logic             push;
   logic             pop;
   logic             gnt_we;

   logic [PTR_W-1:0] fifo_q [OUTST];
   logic [AW-1:0]    rd_q;
   logic [AW-1:0]    wr_q;
   logic [AW:0]      cnt_q;
   logic [AW:0]      cnt_d;
   logic [PTR_W-1:0] head;
   logic             unexp_q;

   logic [NUM_M-1:0] ack;
   logic [NUM_M-1:0] resp;

   // ------------------------------------------------------------------
   // Round-robin grant: first requester at or after rr_ptr, wrapping.
   // ------------------------------------------------------------------
   always_comb begin : p_grant
      int               pos;
      logic [PTR_W-1:0] idx;
      logic             found;
      gnt   = '0;
      found = 1'b0;
      pos   = 0;
      idx   = '0;
      for (int i = 0; i < NUM_M; i++) begin
         pos = int'(rr_ptr_q) + i;
         if (pos >= NUM_M) begin
            pos = pos - NUM_M;
         end
         idx = PTR_W'(pos);
         if (!found && bus.m_req_i[idx]) begin
            gnt   = idx;
            found = 1'b1;
         end
      end
   end

   assign any_req  = |bus.m_req_i;
   assign blocked  = (cnt_q == CNT_FULL);
   // Writes are held off too when full, so nothing overtakes a stalled read.
   assign fwd      = any_req & ~blocked & ~rst_i;
   assign accept   = fwd & bus.s_ack_i;
   assign gnt_we   = bus.m_we_i[gnt];
   assign push     = accept & ~gnt_we;
   assign pop      = bus.s_resp_i & (cnt_q != '0) & ~rst_i;
   assign head     = fifo_q[rd_q];
   assign rr_ptr_d = (gnt == LAST_M) ? '0 : gnt + 1'b1;

   // ------------------------------------------------------------------
   // Slave-side request path
   // ------------------------------------------------------------------
   assign bus.s_req_o    = fwd;
   assign bus.s_we_o     = fwd & gnt_we;
   assign bus.s_addr_bo  = fwd ? bus.m_addr_bi[32*gnt +: 32]  : 32'h0;
   assign bus.s_be_o     = fwd ? bus.m_be_i[4*gnt +: 4]       : 4'h0;
   assign bus.s_wdata_bo = fwd ? bus.m_wdata_bi[32*gnt +: 32] : 32'h0;

   // ------------------------------------------------------------------
   // Master-side ack and response routing
   // ------------------------------------------------------------------
   always_comb begin
      ack = '0;
      if (accept) begin
         ack[gnt] = 1'b1;
      end
   end

   always_comb begin
      resp = '0;
      if (pop) begin
         resp[head] = 1'b1;
      end
   end

   assign bus.m_ack_o      = ack;
   assign bus.m_resp_o     = resp;
   assign bus.m_rdata_bo   = (bus.s_resp_i & ~rst_i) ? bus.s_rdata_bi : 32'h0;
   assign bus.unexp_resp_o = unexp_q & ~rst_i;

   // ------------------------------------------------------------------
   // Read-ID FIFO occupancy
   // ------------------------------------------------------------------
   always_comb begin
      cnt_d = cnt_q;
      unique case ({push, pop})
         2'b10:   cnt_d = cnt_q + 1'b1;
         2'b01:   cnt_d = cnt_q - 1'b1;
         default: cnt_d = cnt_q;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         rr_ptr_q <= '0;
         rd_q     <= '0;
         wr_q     <= '0;
         cnt_q    <= '0;
         unexp_q  <= 1'b0;
      end else begin
         if (accept) begin
            rr_ptr_q <= rr_ptr_d;
         end
         if (push) begin
            fifo_q[wr_q] <= gnt;
            wr_q         <= wr_q + 1'b1;
         end
         if (pop) begin
            rd_q <= rd_q + 1'b1;
         end
         cnt_q <= cnt_d;
         if (bus.s_resp_i && (cnt_q == '0)) begin
            unexp_q <= 1'b1;
         end
      end
   end

`ifdef ARIELE_ARB_STATS_EN
   // ------------------------------------------------------------------
   // Saturating per-master grant counters and a shared stall counter
   // ------------------------------------------------------------------
   logic [15:0] grant_cnt_q [NUM_M];
   logic [15:0] stall_cnt_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int k = 0; k < NUM_M; k++) begin
            grant_cnt_q[k] <= 16'h0;
         end
         stall_cnt_q <= 16'h0;
      end else begin
         if (accept && (grant_cnt_q[gnt] != 16'hFFFF)) begin
            grant_cnt_q[gnt] <= grant_cnt_q[gnt] + 16'h1;
         end
         if (any_req && !accept && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'h1;
         end
      end
   end

   for (genvar k = 0; k < NUM_M; k++) begin : g_stat
      assign stat_grant_bo[16*k +: 16] = rst_i ? 16'h0 : grant_cnt_q[k];
   end
   assign stat_stall_bo = rst_i ? 16'h0 : stall_cnt_q;
`endif

endmodule

// File: tb/tb_ariele_slave_arbiter.sv
// Self-checking bench for ariele_slave_arbiter: a queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_ariele_slave_arbiter;

   localparam int NUM_M = 5;
   localparam int OUTST = 4;
   localparam int PTR_W = 3;

   logic clk;
   logic rst;

   int n_cmp  = 0;
   int n_fail = 0;

   ariele_slave_arbiter_if #(.NUM_M(NUM_M)) bus ();

`ifdef ARIELE_ARB_STATS_EN
   logic [NUM_M*16-1:0] stat_grant;
   logic [15:0]         stat_stall;
`endif

   ariele_slave_arbiter #(
      .NUM_M(NUM_M),
      .OUTST(OUTST),
      .PTR_W(PTR_W)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus)
`ifdef ARIELE_ARB_STATS_EN
      ,
      .stat_grant_bo(stat_grant),
      .stat_stall_bo(stat_stall)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------
   // Reference model: rotating priority, a queue of read issuers.
   // ------------------------------------------------------------------
   int m_rr;
   int m_q[$];
   bit m_unexp;
   int m_gcnt[NUM_M];
   int m_stall;

   always @(negedge clk) begin : cmp
      int               g;
      bit               fwd;
      bit               acc;
      logic [NUM_M-1:0] e_ack;
      logic [NUM_M-1:0] e_resp;
      logic [31:0]      e_addr;
      logic [31:0]      e_wdata;
      logic [3:0]       e_be;
      logic             e_we;
      logic [31:0]      e_rdata;
      g = -1;
      for (int i = 0; i < NUM_M; i++) begin
         int k;
         k = (m_rr + i) % NUM_M;
         if (g < 0 && bus.m_req_i[k]) g = k;
      end
      fwd     = !rst && (g >= 0) && (m_q.size() < OUTST);
      acc     = fwd && bus.s_ack_i;
      e_ack   = '0;
      e_resp  = '0;
      e_addr  = '0;
      e_wdata = '0;
      e_be    = '0;
      e_we    = 1'b0;
      if (fwd) begin
         e_we    = bus.m_we_i[g];
         e_addr  = bus.m_addr_bi[32*g +: 32];
         e_be    = bus.m_be_i[4*g +: 4];
         e_wdata = bus.m_wdata_bi[32*g +: 32];
         if (acc) e_ack[g] = 1'b1;
      end
      if (!rst && bus.s_resp_i && m_q.size() > 0) e_resp[m_q[0]] = 1'b1;
      e_rdata = (!rst && bus.s_resp_i) ? bus.s_rdata_bi : 32'h0;

      chk("s_req", bus.s_req_o, fwd);
      chk("s_we", bus.s_we_o, e_we);
      chk("s_addr", bus.s_addr_bo, e_addr);
      chk("s_be", bus.s_be_o, e_be);
      chk("s_wdata", bus.s_wdata_bo, e_wdata);
      chk("m_ack", bus.m_ack_o, e_ack);
      chk("m_resp", bus.m_resp_o, e_resp);
      chk("m_rdata", bus.m_rdata_bo, e_rdata);
      chk("unexp", bus.unexp_resp_o, !rst && m_unexp);
`ifdef ARIELE_ARB_STATS_EN
      for (int k = 0; k < NUM_M; k++) begin
         chk("stat_grant", stat_grant[16*k +: 16], rst ? 0 : m_gcnt[k]);
      end
      chk("stat_stall", stat_stall, rst ? 0 : m_stall);
`endif

      // Next state, as seen at the coming rising edge.
      if (rst) begin
         m_rr = 0;
         m_q.delete();
         m_unexp = 1'b0;
         for (int k = 0; k < NUM_M; k++) m_gcnt[k] = 0;
         m_stall = 0;
      end else begin
         if (bus.s_resp_i) begin
            if (m_q.size() > 0) void'(m_q.pop_front());
            else m_unexp = 1'b1;
         end
         if (acc) begin
            m_rr = (g + 1) % NUM_M;
            if (!bus.m_we_i[g]) m_q.push_back(g);
            if (m_gcnt[g] < 65535) m_gcnt[g]++;
         end
         if (g >= 0 && !acc && m_stall < 65535) m_stall++;
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers: inputs change 1 time unit after the rising edge.
   // ------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_inputs();
      bus.m_req_i    = '0;
      bus.m_we_i     = '0;
      bus.m_addr_bi  = '0;
      bus.m_be_i     = '0;
      bus.m_wdata_bi = '0;
      bus.s_ack_i    = 1'b0;
      bus.s_resp_i   = 1'b0;
      bus.s_rdata_bi = '0;
   endtask

   task automatic set_m(input int k, input logic we, input logic [31:0] addr);
      bus.m_we_i[k]              = we;
      bus.m_addr_bi[32*k +: 32]  = addr;
      bus.m_be_i[4*k +: 4]       = 4'(k + 9);
      bus.m_wdata_bi[32*k +: 32] = addr ^ 32'hA5A5_0000;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_inputs();
      tick();
      rst = 1'b0;
   endtask

   logic [NUM_M-1:0] t1_exp [5];
   logic [NUM_M-1:0] t4_exp [3];

   initial begin
      t1_exp = '{5'b00001, 5'b00100, 5'b10000, 5'b00001, 5'b00100};
      t4_exp = '{5'b01000, 5'b00001, 5'b10000};

      // Reset with busy inputs: everything must stay quiet.
      rst = 1'b1;
      clear_inputs();
      bus.m_req_i  = '1;
      bus.s_ack_i  = 1'b1;
      bus.s_resp_i = 1'b1;
      @(negedge clk);
      chk("rst_s_req", bus.s_req_o, 0);
      chk("rst_m_ack", bus.m_ack_o, 0);
      chk("rst_m_resp", bus.m_resp_o, 0);
      tick();
      tick();

      // 1: writes from masters 0,2,4 rotate 0,2,4,0,2.
      rst = 1'b0;
      clear_inputs();
      for (int k = 0; k < NUM_M; k++) set_m(k, 1'b1, 32'h1000 + 32'(k * 4));
      bus.m_req_i = 5'b10101;
      bus.s_ack_i = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t1_ack", bus.m_ack_o, t1_exp[i]);
         tick();
      end

      // 2: reads from masters 1 and 3, responses routed in issue order.
      do_reset();
      set_m(1, 1'b0, 32'h10);
      set_m(3, 1'b0, 32'h20);
      bus.m_req_i = 5'b01010;
      bus.s_ack_i = 1'b1;
      @(negedge clk);
      chk("t2_ack1", bus.m_ack_o, 5'b00010);
      chk("t2_addr1", bus.s_addr_bo, 32'h10);
      tick();
      bus.m_req_i = 5'b01000;
      @(negedge clk);
      chk("t2_ack3", bus.m_ack_o, 5'b01000);
      chk("t2_addr3", bus.s_addr_bo, 32'h20);
      tick();
      bus.m_req_i    = '0;
      bus.s_ack_i    = 1'b0;
      bus.s_resp_i   = 1'b1;
      bus.s_rdata_bi = 32'hD1D1_0001;
      @(negedge clk);
      chk("t2_resp1", bus.m_resp_o, 5'b00010);
      chk("t2_rdata1", bus.m_rdata_bo, 32'hD1D1_0001);
      tick();
      bus.s_rdata_bi = 32'hD2D2_0002;
      @(negedge clk);
      chk("t2_resp2", bus.m_resp_o, 5'b01000);
      chk("t2_rdata2", bus.m_rdata_bo, 32'hD2D2_0002);
      tick();

      // 3: four outstanding reads block the port until one response drains.
      do_reset();
      for (int k = 0; k < NUM_M; k++) set_m(k, 1'b0, 32'h100 + 32'(k * 4));
      bus.m_req_i = 5'b01111;
      bus.s_ack_i = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("t3_ack", bus.m_ack_o, 5'(1 << i));
         tick();
      end
      @(negedge clk);
      chk("t3_blk_req", bus.s_req_o, 0);
      chk("t3_blk_ack", bus.m_ack_o, 0);
      tick();
      bus.s_resp_i   = 1'b1;
      bus.s_rdata_bi = 32'h0000_0033;
      @(negedge clk);
      chk("t3_blk_req2", bus.s_req_o, 0);
      chk("t3_resp0", bus.m_resp_o, 5'b00001);
      tick();
      bus.s_resp_i = 1'b0;
      @(negedge clk);
      chk("t3_unblk_req", bus.s_req_o, 1);
      chk("t3_unblk_ack", bus.m_ack_o, 5'b00001);
      tick();
      bus.m_req_i  = '0;
      bus.s_ack_i  = 1'b0;
      bus.s_resp_i = 1'b1;
      @(negedge clk);
      chk("t3_resp1", bus.m_resp_o, 5'b00010);
      tick();

      // 4: three outstanding, read accepted while a response pops.
      bus.m_req_i    = 5'b10000;
      bus.s_ack_i    = 1'b1;
      bus.s_resp_i   = 1'b1;
      bus.s_rdata_bi = 32'hD3D3_0003;
      @(negedge clk);
      chk("t4_req", bus.s_req_o, 1);
      chk("t4_ack", bus.m_ack_o, 5'b10000);
      chk("t4_resp", bus.m_resp_o, 5'b00100);
      chk("t4_rdata", bus.m_rdata_bo, 32'hD3D3_0003);
      tick();
      bus.m_req_i = '0;
      bus.s_ack_i = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t4_drain", bus.m_resp_o, t4_exp[i]);
         tick();
      end

      // 5: response with nothing outstanding is flagged until reset.
      @(negedge clk);
      chk("t5_resp", bus.m_resp_o, 0);
      chk("t5_unexp_pre", bus.unexp_resp_o, 0);
      tick();
      bus.s_resp_i = 1'b0;
      @(negedge clk);
      chk("t5_unexp", bus.unexp_resp_o, 1);
      tick();
      tick();
      @(negedge clk);
      chk("t5_unexp_hold", bus.unexp_resp_o, 1);
      do_reset();
      @(negedge clk);
      chk("t5_unexp_clr", bus.unexp_resp_o, 0);

      // Mixed traffic, checked against the model only.
      for (int i = 0; i < 24; i++) begin
         bus.m_req_i    = 5'((i * 13 + 5) % 32);
         bus.m_we_i     = 5'((i * 11) % 32);
         for (int k = 0; k < NUM_M; k++) begin
            bus.m_addr_bi[32*k +: 32] = 32'(i * 256 + k);
         end
         bus.s_ack_i    = (i % 3) != 2;
         bus.s_resp_i   = (i % 4) == 1;
         bus.s_rdata_bi = 32'(i) + 32'hC000_0000;
         tick();
      end

`ifdef ARIELE_ARB_STATS_EN
      // 6: grant counter saturates; reset mid-read clears counters and FIFO.
      do_reset();
      set_m(2, 1'b1, 32'h200);
      bus.m_req_i = 5'b00100;
      bus.s_ack_i = 1'b1;
      repeat (65600) tick();
      @(negedge clk);
      chk("t6_sat", stat_grant[47:32], 16'hFFFF);
      set_m(2, 1'b0, 32'h204);
      tick();
      bus.m_req_i = '0;
      bus.s_ack_i = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_grant_clr", stat_grant, 0);
      chk("t6_stall_clr", stat_stall, 0);
      tick();
      bus.s_resp_i = 1'b1;
      @(negedge clk);
      chk("t6_resp_flushed", bus.m_resp_o, 0);
      tick();
      bus.s_resp_i = 1'b0;
      @(negedge clk);
      chk("t6_unexp", bus.unexp_resp_o, 1);
      tick();
`endif

      clear_inputs();
      tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
